pulse_gen: RTL and testbench

Programmable pulse generator driving one output pin, the transmit-side counterpart of the input glitch filter. On a start request it emits a burst of clean pulses with a configurable polarity, pulse width and gap width. It reports busy status and raises a one-cycle done interrupt. Width and gap use the filter's 4-bit window encoding, so a pulse of a given code survives a filter set to the same code.

---
 rtl/pulse_gen.sv | 140 ++++++++++++++
 tb/tb_pulse_gen.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/pulse_gen.sv
// Programmable pulse-burst generator: start launches N pulses of a coded width
// separated by coded gaps, with busy status and a one-cycle done interrupt.
module pulse_gen (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       pulse_pol_i,
    input  logic [3:0] width_sel_i,
    input  logic [3:0] gap_sel_i,
    input  logic [3:0] count_i,
    input  logic       int_en_i,
    input  logic       start_i,
    input  logic       stop_i,
    output logic       data_out,
    output logic       busy_o,
    output logic       done_int_o
);

    typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_t;

    // Same window encoding as the input glitch filter; a phase lasts L+1 cycles.
    function automatic logic [10:0] load_val(input logic [3:0] code);
        logic [10:0] v;
        case (code)
            4'd0:    v = 11'd3;
            4'd1:    v = 11'd7;
            4'd2:    v = 11'd15;
            4'd3:    v = 11'd31;
            4'd4:    v = 11'd47;
            4'd5:    v = 11'd63;
            4'd6:    v = 11'd127;
            4'd7:    v = 11'd255;
            4'd8:    v = 11'd511;
            4'd9:    v = 11'd639;
            4'd10:   v = 11'd767;
            4'd11:   v = 11'd895;
            4'd12:   v = 11'd1023;
            4'd13:   v = 11'd1279;
            4'd14:   v = 11'd1535;
            default: v = 11'd2047;
        endcase
        return v;
    endfunction

    state_t      state_q, state_d;
    logic [10:0] cnt_q, cnt_d;
    logic [3:0]  rem_q, rem_d;
    logic [3:0]  wsel_q, wsel_d, gsel_q, gsel_d;
    logic        pol_q, pol_d;
    logic        stop_pend_q, stop_pend_d;
    logic        data_d, done_d;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            wsel_q      <= '0;
            gsel_q      <= '0;
            pol_q       <= 1'b0;
            stop_pend_q <= 1'b0;
            data_out    <= 1'b0;
            done_int_o  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            wsel_q      <= wsel_d;
            gsel_q      <= gsel_d;
            pol_q       <= pol_d;
            stop_pend_q <= stop_pend_d;
            data_out    <= data_d;
            done_int_o  <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        wsel_d      = wsel_q;
        gsel_d      = gsel_q;
        pol_d       = pol_q;
        stop_pend_d = stop_pend_q;
        data_d      = !pulse_pol_i;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i && !stop_i) begin
                    state_d = ACTIVE;
                    pol_d   = pulse_pol_i;
                    wsel_d  = width_sel_i;
                    gsel_d  = gap_sel_i;
                    rem_d   = count_i;
                    cnt_d   = load_val(width_sel_i);
                end
            end
            ACTIVE: begin
                // A stop never truncates the pulse in flight; it only skips the gap.
                if (stop_i) stop_pend_d = 1'b1;
                if (cnt_q == 11'd0) begin
                    if (rem_q == 4'd1 || stop_pend_q || stop_i) begin
                        state_d = IDLE;
                    end else begin
                        state_d = GAP;
                        cnt_d   = load_val(gsel_q);
                        if (rem_q != 4'd0) rem_d = rem_q - 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 11'd1;
                end
            end
            GAP: begin
                if (stop_i) begin
                    state_d = IDLE;
                end else if (cnt_q == 11'd0) begin
                    state_d = ACTIVE;
                    cnt_d   = load_val(wsel_q);
                end else begin
                    cnt_d = cnt_q - 11'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d == IDLE) begin
            stop_pend_d = 1'b0;
            if (state_q != IDLE) done_d = int_en_i;
        end

        case (state_d)
            ACTIVE:  data_d = pol_d;
            GAP:     data_d = !pol_d;
            default: data_d = !pulse_pol_i;
        endcase
    end

    assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_pulse_gen.sv
// Scoreboard bench for pulse_gen: the driver queues the expected per-cycle
// {data_out, busy_o, done_int_o} triples, the monitor pops one per clock.
module tb_pulse_gen;

    logic       clk_i = 1'b0;
    logic       rstn_i;
    logic       pulse_pol_i;
    logic [3:0] width_sel_i, gap_sel_i, count_i;
    logic       int_en_i, start_i, stop_i;
    logic       data_out, busy_o, done_int_o;

    typedef struct packed {
        logic d;
        logic b;
        logic i;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    string tname   = "reset";

    pulse_gen dut (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .pulse_pol_i(pulse_pol_i),
        .width_sel_i(width_sel_i),
        .gap_sel_i  (gap_sel_i),
        .count_i    (count_i),
        .int_en_i   (int_en_i),
        .start_i    (start_i),
        .stop_i     (stop_i),
        .data_out   (data_out),
        .busy_o     (busy_o),
        .done_int_o (done_int_o)
    );

    always #5 clk_i = ~clk_i;

    // Monitor: samples just after each active edge.
    always begin
        @(posedge clk_i);
        #1;
        cyc++;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (data_out !== e.d || busy_o !== e.b || done_int_o !== e.i) begin
                failures++;
                $display("FAIL %s cyc=%0d got d/b/i=%b%b%b required=%b%b%b",
                         tname, cyc, data_out, busy_o, done_int_o, e.d, e.b, e.i);
            end
        end
    end

    task automatic push(input logic d, input logic b, input logic i, input int n);
        exp_t e;
        e.d = d; e.b = b; e.i = i;
        for (int k = 0; k < n; k++) exp_q.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 6000) begin
            @(negedge clk_i);
            n++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL %s timeout got pending=%0d required=0", tname, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic cfg(input logic pol, input logic [3:0] w, input logic [3:0] g,
                       input logic [3:0] c, input logic ie);
        pulse_pol_i = pol; width_sel_i = w; gap_sel_i = g; count_i = c; int_en_i = ie;
    endtask

    initial begin
        rstn_i = 1'b0; start_i = 1'b0; stop_i = 1'b0;
        cfg(1'b1, 4'd0, 4'd0, 4'd0, 1'b1);
        push(0, 0, 0, 3);
        repeat (3) @(negedge clk_i);
        rstn_i = 1'b1;
        push(0, 0, 0, 3);
        drain();

        // Basic burst of two 4-cycle pulses, then a restart during the done cycle.
        tname = "basic";
        @(negedge clk_i);
        cfg(1'b1, 4'd0, 4'd0, 4'd2, 1'b1);
        start_i = 1'b1;
        push(1, 1, 0, 4); push(0, 1, 0, 4); push(1, 1, 0, 4); push(0, 0, 1, 1);
        push(1, 1, 0, 4); push(0, 0, 1, 1); push(0, 0, 0, 2);
        @(negedge clk_i); start_i = 1'b0;
        repeat (12) @(negedge clk_i);
        count_i = 4'd1; start_i = 1'b1;
        @(negedge clk_i); start_i = 1'b0;
        drain();

        // Inverted polarity, widest code, interrupt disabled.
        tname = "inv_max";
        @(negedge clk_i);
        cfg(1'b0, 4'd15, 4'd0, 4'd1, 1'b0);
        push(1, 0, 0, 1);
        @(negedge clk_i);
        start_i = 1'b1;
        push(0, 1, 0, 2048); push(1, 0, 0, 3);
        @(negedge clk_i); start_i = 1'b0;
        drain();
        @(negedge clk_i);
        pulse_pol_i = 1'b1;
        push(0, 0, 0, 1);
        drain();

        // Three pulses, mid-table codes: 16-cycle pulse, 48-cycle gap.
        tname = "count3";
        @(negedge clk_i);
        cfg(1'b1, 4'd2, 4'd4, 4'd3, 1'b1);
        start_i = 1'b1;
        push(1, 1, 0, 16); push(0, 1, 0, 48); push(1, 1, 0, 16); push(0, 1, 0, 48);
        push(1, 1, 0, 16); push(0, 0, 1, 1); push(0, 0, 0, 2);
        @(negedge clk_i); start_i = 1'b0;
        drain();

        // Continuous mode, stop mid third pulse: pulse completes, no trailing gap.
        tname = "stop_active";
        @(negedge clk_i);
        cfg(1'b1, 4'd1, 4'd1, 4'd0, 1'b1);
        start_i = 1'b1;
        push(1, 1, 0, 8); push(0, 1, 0, 8); push(1, 1, 0, 8); push(0, 1, 0, 8);
        push(1, 1, 0, 8); push(0, 0, 1, 1); push(0, 0, 0, 3);
        @(negedge clk_i); start_i = 1'b0;
        repeat (34) @(negedge clk_i);
        stop_i = 1'b1;
        @(negedge clk_i); stop_i = 1'b0;
        drain();

        // Stop during a gap leaves on the next edge.
        tname = "stop_gap";
        @(negedge clk_i);
        start_i = 1'b1;
        push(1, 1, 0, 8); push(0, 1, 0, 2); push(0, 0, 1, 1); push(0, 0, 0, 3);
        @(negedge clk_i); start_i = 1'b0;
        repeat (9) @(negedge clk_i);
        stop_i = 1'b1;
        @(negedge clk_i); stop_i = 1'b0;
        drain();

        // Start while busy and width changes mid-burst are ignored.
        tname = "guard";
        @(negedge clk_i);
        cfg(1'b1, 4'd0, 4'd0, 4'd2, 1'b1);
        start_i = 1'b1;
        push(1, 1, 0, 4); push(0, 1, 0, 4); push(1, 1, 0, 4); push(0, 0, 1, 1);
        push(0, 0, 0, 2);
        @(negedge clk_i); start_i = 1'b0; width_sel_i = 4'd5; gap_sel_i = 4'd7;
        repeat (2) @(negedge clk_i); start_i = 1'b1;
        @(negedge clk_i); start_i = 1'b0;
        repeat (5) @(negedge clk_i); start_i = 1'b1;
        @(negedge clk_i); start_i = 1'b0;
        drain();

        // Simultaneous start and stop in IDLE.
        tname = "start_stop";
        @(negedge clk_i);
        start_i = 1'b1; stop_i = 1'b1;
        push(0, 0, 0, 4);
        @(negedge clk_i); start_i = 1'b0; stop_i = 1'b0;
        drain();

        // Reset mid-pulse clears everything at once; no done afterwards.
        tname = "reset_mid";
        @(negedge clk_i);
        cfg(1'b1, 4'd3, 4'd0, 4'd1, 1'b1);
        start_i = 1'b1;
        push(1, 1, 0, 5); push(0, 0, 0, 40);
        @(negedge clk_i); start_i = 1'b0;
        repeat (4) @(negedge clk_i);
        rstn_i = 1'b0;
        repeat (3) @(negedge clk_i);
        rstn_i = 1'b1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
